// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NCHAN  = 4,
    parameter int DWIDTH = 16
);
    localparam int TAGW = $clog2(NCHAN);

    logic [NCHAN-1:0]        req_valid;
    logic [NCHAN*DWIDTH-1:0] req_data;
    logic [NCHAN-1:0]        req_ready;
    logic                    fifo_wen;
    logic [TAGW+DWIDTH-1:0]  fifo_wdata;
    logic                    fifo_full;
    logic                    fifo_almost_full;
    logic                    busy;
    logic [TAGW-1:0]         grant_id;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_almost_full,
        output req_ready, fifo_wen, fifo_wdata, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_almost_full,
        input  req_ready, fifo_wen, fifo_wdata, busy, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
    parameter int NCHAN     = 4,
    parameter int DWIDTH    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              wclk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int TAGW = $clog2(NCHAN);
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0]   BEAT_MAX  = BW'(MAX_BURST);
    localparam logic [TAGW-1:0] LAST_CH   = TAGW'(NCHAN - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TAGW-1:0]        r_rr_ptr;
    logic [TAGW-1:0]        r_grant_id;
    logic [BW-1:0]          r_beat_cnt;
    logic                   r_fifo_wen;
    logic [TAGW+DWIDTH-1:0] r_fifo_wdata;

    logic [TAGW-1:0]        w_arb_idx;
    logic                   w_arb_found;
    logic [TAGW-1:0]        w_ptr_after;
    logic                   w_space_ok;
    logic                   w_sel_valid;
    logic                   w_accept;
    logic                   w_last_beat;
    logic [DWIDTH-1:0]      w_words [NCHAN];
    int                     w_scan;

    genvar g;
    for (g = 0; g < NCHAN; g++) begin : g_unpack
        assign w_words[g] = bus.req_data[g*DWIDTH +: DWIDTH];
    end

    // Almost-full also blocks: an accept now is written next cycle, when that write may fill the FIFO.
    assign w_space_ok  = ~bus.fifo_full & ~bus.fifo_almost_full;
    assign w_sel_valid = bus.req_valid[r_grant_id];
    assign w_accept    = (r_state == ST_GRANT) & w_sel_valid & w_space_ok;
    assign w_last_beat = (r_beat_cnt == BEAT_LAST);
    assign w_ptr_after = (r_grant_id == LAST_CH) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        w_arb_idx   = r_rr_ptr;
        w_arb_found = 1'b0;
        w_scan      = 0;
        for (int i = 0; i < NCHAN; i++) begin
            w_scan = int'(r_rr_ptr) + i;
            if (w_scan >= NCHAN) w_scan = w_scan - NCHAN;
            if (!w_arb_found && bus.req_valid[TAGW'(w_scan)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = TAGW'(w_scan);
            end
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_arb_found) w_state_nxt = ST_GRANT;
            ST_GRANT: if (!w_sel_valid || (w_accept && w_last_beat)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.busy      = 1'b0;
        if (r_state == ST_GRANT) begin
            bus.busy                  = 1'b1;
            bus.req_ready[r_grant_id] = w_sel_valid & w_space_ok;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_fifo_wen   <= 1'b0;
            r_fifo_wdata <= '0;
        end else begin
            r_fifo_wen <= w_accept;
            if (r_state == ST_IDLE && w_arb_found) begin
                r_grant_id <= w_arb_idx;
                r_beat_cnt <= '0;
            end
            if (w_accept) begin
                r_fifo_wdata <= {r_grant_id, w_words[r_grant_id]};
                if (r_beat_cnt != BEAT_MAX) r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (r_state == ST_GRANT && w_state_nxt == ST_IDLE) r_rr_ptr <= w_ptr_after;
        end
    end

    assign bus.fifo_wen   = r_fifo_wen;
    assign bus.fifo_wdata = r_fifo_wdata;
    assign bus.grant_id   = r_grant_id;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `async_fifo` write port among `NCHAN` sample sources in the `wclk` domain. Each source presents words on a valid/ready handshake. The arbiter grants one source at a time for a bounded burst and forwards the accepted words, tagged with the source index, into the FIFO. It uses `fifo_full`/`fifo_almost_full` so that no write is ever attempted into a full FIFO.

## Interface
Parameters:
- `NCHAN`, 4: number of requesters, at least 2.
- `DWIDTH`, 16: payload width per requester.
- `MAX_BURST`, 8: maximum words accepted per grant, at least 1.
- `TAGW`, derived as `$clog2(NCHAN)`: tag width, not overridable.

Ports:
- `wclk` in 1: write-domain clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. Clock `wclk`.
- `req_valid` in `NCHAN`: per-source word valid.
- `req_data` in `NCHAN*DWIDTH`: source i occupies bits `[i*DWIDTH +: DWIDTH]`.
- `req_ready` out `NCHAN`: per-source accept strobe (combinational); one-hot or zero.
- `fifo_wen` out 1: registered FIFO write enable.
- `fifo_wdata` out `TAGW+DWIDTH`: registered `{tag, data}` word.
- `fifo_full` in 1: FIFO full flag.
- `fifo_almost_full` in 1: FIFO full-next flag (this cycle's write fills it).
- `busy` out 1: a grant is held (state GRANT).
- `grant_id` out `TAGW`: index of the currently granted source; holds its last value in IDLE.

## Operation
- `space_ok = ~fifo_full & ~fifo_almost_full`. A word accepted in cycle t is written at t+1, so this condition guarantees the write lands in a non-full FIFO.
- FSM states:
  - IDLE:
    - `req_ready = 0`.
    - If any `req_valid` is high, select the first set bit scanning upward from `rr_ptr` modulo `NCHAN`.
    - Register that index into `grant_id`, clear `beat_cnt`, and go to GRANT.
    - Arbitration is independent of `space_ok`.
  - GRANT:
    - `req_ready[grant_id] = req_valid[grant_id] & space_ok`.
    - Each accept loads `fifo_wdata <= {grant_id, req_data[grant_id]}`, sets `fifo_wen <= 1`, and increments `beat_cnt`.
    - Burst ends, returning to IDLE with `rr_ptr <= grant_id+1` modulo `NCHAN`, on either event:
      - the accept that makes `beat_cnt == MAX_BURST`;
      - any cycle in which `req_valid[grant_id]` is low.
    - If `req_valid[grant_id]` is high but `space_ok` is low, hold the grant and stall; stalled cycles do not count toward the burst.
- `fifo_wen` is 0 in every cycle not following an accept. `fifo_wdata` holds its last value when `fifo_wen` is 0.
- `beat_cnt` is `$clog2(MAX_BURST+1)` bits wide and saturates at `MAX_BURST`; the FSM never increments it past that value.
- `rr_ptr` wraps from `NCHAN-1` to 0. For non-power-of-two `NCHAN`, the modulo is explicit.
- Sources must hold `req_data` stable while valid and not ready. The arbiter never reorders words within a source.

## Timing
- Reset values, asynchronous:
  - state IDLE
  - `rr_ptr = 0`, `grant_id = 0`, `beat_cnt = 0`
  - `fifo_wen = 0`, `fifo_wdata = 0`
  - `busy = 0`, `req_ready = 0`
- Reset mid-burst: `fifo_wen` drops asynchronously and an in-flight registered word is discarded. The source sees its handshake as completed only for words whose ready was already sampled.
- Latency:
  - `req_valid` rises at t in IDLE → grant at t+1 → earliest `req_ready` at t+1 → `fifo_wen` at t+2.
  - Sustained throughput is 1 word per cycle within a burst.
  - There is 1 dead cycle (IDLE) between bursts.
- Full handling:
  - The FIFO holds `full = 1` after reset until its internal reset synchroniser releases; the arbiter stalls in GRANT throughout.
  - The FIFO clears full late, so throughput after a full event is pessimistic but never overflows.
- Simultaneous events:
  - Valid drop and `MAX_BURST` reached in the same cycle: single return to IDLE.
  - Source re-asserts valid in the IDLE cycle: it is eligible only after all others in round-robin order.
- Fairness: with all sources continuously valid and space available, each source receives exactly `MAX_BURST` words per `NCHAN*(MAX_BURST+1)` cycles.

## Test plan
- Reset, all `req_valid` low for 20 cycles:
  - `fifo_wen`, `req_ready`, and `busy` stay 0.
  - `grant_id = 0`.
- Only source 2 valid continuously, FIFO empty, `MAX_BURST = 8`:
  - First write at t+2.
  - 8 writes tagged 2 on consecutive cycles, then 1 gap cycle, repeating.
- All 4 sources continuously valid:
  - Write tags follow 0×8, 1×8, 2×8, 3×8, 0×8, with one gap cycle between groups.
  - Data from each source is in order.
- Source 1 valid for 3 words then low:
  - Exactly 3 writes tagged 1.
  - Return to IDLE.
  - Next grant goes to source 2 if it is valid.
- Drive `fifo_almost_full = 1` for 5 cycles mid-burst:
  - `req_ready` is 0 for those cycles and no `fifo_wen` follows them.
  - The burst resumes with `beat_cnt` preserved; the total is still 8 words.
- Assert `rst_n` low mid-burst at beat 4:
  - `fifo_wen` falls immediately.
  - After release the state is IDLE and the first grant goes to the lowest valid index starting from 0.
